// File: rtl/share_recombiner_pkg.sv
// Shared types for the masked-share recombiner.
//   recomb_state_t : two-state control FSM encoding (collecting shares / presenting value)
package share_recombiner_pkg;

  typedef enum logic {
    RECOMB_COLLECT = 1'b0,
    RECOMB_OUTPUT  = 1'b1
  } recomb_state_t;

endpackage : share_recombiner_pkg

// File: rtl/share_recombiner.sv
// share_recombiner
//   Receives the NUM_SHARES Boolean shares of one masked value serially (share 0 first,
//   one per valid/ready handshake), XOR-accumulates them, and presents the unmasked value
//   on a valid/ready output once every share has arrived. out_value reads as zero whenever
//   no complete recombination is being presented.
// Ports
//   in_clock        : clock, all state updates on rising edge
//   in_reset        : synchronous active-low reset
//   in_share        : incoming share (WIDTH bits)
//   in_share_valid  : in_share is valid
//   out_share_ready : block accepts a share this cycle
//   out_value       : recombined value, zero when out_value_valid=0
//   out_value_valid : out_value holds a complete recombination
//   in_value_ready  : consumer accepts out_value this cycle
module share_recombiner
  import share_recombiner_pkg::*;
#(
  parameter int NUM_SHARES = 2,
  parameter int WIDTH      = 8
) (
  input  logic             in_clock,
  input  logic             in_reset,
  input  logic [WIDTH-1:0] in_share,
  input  logic             in_share_valid,
  output logic             out_share_ready,
  output logic [WIDTH-1:0] out_value,
  output logic             out_value_valid,
  input  logic             in_value_ready
);

  // Width guard keeps elaboration well-formed long enough for the error below to fire.
  localparam int IDX_W = (NUM_SHARES >= 2) ? $clog2(NUM_SHARES) : 1;

  typedef logic [IDX_W-1:0] share_idx_t;
  typedef logic [WIDTH-1:0] value_t;

  localparam share_idx_t LAST_IDX = share_idx_t'(NUM_SHARES - 1);

  if (NUM_SHARES < 2) begin : g_bad_num_shares
    $error("share_recombiner: NUM_SHARES must be >= 2");
  end

  recomb_state_t state_q, state_d;
  share_idx_t    count_q, count_d;
  value_t        acc_q,   acc_d;
  // Low while reset is held and for the reset cycle itself, so the block never
  // advertises ready before reset has been released.
  logic          armed_q;

  logic share_hs;
  logic value_hs;

  assign share_hs = in_share_valid & out_share_ready;
  assign value_hs = out_value_valid & in_value_ready;

  // State register: reset dominates any handshake in the same cycle.
  always_ff @(posedge in_clock) begin
    if (!in_reset) begin
      state_q <= RECOMB_COLLECT;
      count_q <= '0;
      acc_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      armed_q <= 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    case (state_q)
      RECOMB_COLLECT: begin
        if (share_hs) begin
          // Share 0 loads, so nothing from a previous value can leak into this one.
          acc_d = (count_q == '0) ? in_share : (acc_q ^ in_share);
          if (count_q == LAST_IDX) begin
            count_d = '0;
            state_d = RECOMB_OUTPUT;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      RECOMB_OUTPUT: begin
        if (value_hs) begin
          acc_d   = '0;
          state_d = RECOMB_COLLECT;
        end
      end
      default: begin
        state_d = RECOMB_COLLECT;
        count_d = '0;
        acc_d   = '0;
      end
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    out_share_ready = armed_q & (state_q == RECOMB_COLLECT);
    out_value_valid = (state_q == RECOMB_OUTPUT);
    out_value       = out_value_valid ? acc_q : '0;
  end

endmodule : share_recombiner
